// File: rtl/seq_alu.sv
// seq_alu: registered, valid/ready handshaked ALU with an iterative
// shift-add multiplier. One operation is in flight at a time; non-MUL ops
// complete in one cycle, MUL takes WIDTH cycles.
module seq_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       alu_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [SHW-1:0]   cnt;

    logic             accept;
    logic             is_mul;
    logic             is_illegal;
    logic             mul_done;
    logic [WIDTH-1:0] comb_res;

    // Single-cycle operations; MUL and illegal codes fall through to zero.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [3:0]       op);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sbv;
        logic [SHW-1:0]          sh;
        sa  = a;
        sbv = b;
        sh  = b[SHW-1:0];
        case (op)
            OP_AND:  alu_fn = a & b;
            OP_OR:   alu_fn = a | b;
            OP_ADD:  alu_fn = a + b;
            OP_XOR:  alu_fn = a ^ b;
            OP_SLL:  alu_fn = a << sh;
            OP_SRL:  alu_fn = a >> sh;
            OP_SUB:  alu_fn = a - b;
            OP_SLT:  alu_fn = {{(WIDTH-1){1'b0}}, (sa < sbv)};
            OP_SRA:  alu_fn = sa >>> sh;
            OP_SLTU: alu_fn = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_fn = '0;
        endcase
    endfunction

    // Output register is freed in the same cycle it drains, so in_ready
    // looks straight through to out_ready.
    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign is_mul     = (alu_c == OP_MUL);
    assign is_illegal = (alu_c > OP_MUL);
    assign mul_done   = (state == MUL) && (cnt == SHW'(WIDTH - 1));
    assign comb_res   = alu_fn(in1, in2, alu_c);
    assign acc_nxt    = acc + (mplier[0] ? mcand : '0);

    // Next-state logic: MUL entered on a MUL accept, left on the last step.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && is_mul) state_nxt = MUL;
            MUL:  if (mul_done)         state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // State, output register and multiplier datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;

            // --- output stage: load new result or drain the current one ---
            if (accept && !is_mul) begin
                result    <= comb_res;
                zero      <= (comb_res == '0);
                err       <= is_illegal;
                out_valid <= 1'b1;
            end else if (mul_done) begin
                result    <= acc_nxt;
                zero      <= (acc_nxt == '0);
                err       <= 1'b0;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // --- multiplier stage: one shift-add step per cycle ---
            if (accept && is_mul) begin
                mcand  <= in1;
                mplier <= in2;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == MUL) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + SHW'(1);
            end
        end
    end

endmodule
